// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus: two requester ports, the shared
// memory port and status outputs, bundled for the arbiter.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;

  logic [DW-1:0] rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [15:0]   gnt_cnt0;
  logic [15:0]   gnt_cnt1;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    input  mem_rdata,
    output m0_gnt, m0_rvalid,
    output m1_gnt, m1_rvalid,
    output rdata, mem_we, mem_addr, mem_wdata,
    output busy, gnt_cnt0, gnt_cnt1
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    output mem_rdata,
    input  m0_gnt, m0_rvalid,
    input  m1_gnt, m1_rvalid,
    input  rdata, mem_we, mem_addr, mem_wdata,
    input  busy, gnt_cnt0, gnt_cnt1
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter giving a core port and a debug/loader
// port shared access to one data memory of fixed read latency.
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 0
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_e        state_q, state_d;
  logic          own_q, own_d;
  logic          last_q, last_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [15:0]   gnt_cnt0_q, gnt_cnt0_d;
  logic [15:0]   gnt_cnt1_q, gnt_cnt1_d;

  logic          win;
  logic          gnt0, gnt1;
  logic          rv0, rv1;
  logic          mwe;
  logic [AW-1:0] maddr;
  logic [DW-1:0] mwdata;

  // last_q=1 means port 1 was granted last, so port 0 wins a tie
  assign win = bus.m1_req & (~bus.m0_req | ~last_q);

  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rv0     = 1'b0;
    rv1     = 1'b0;
    mwe     = 1'b0;
    maddr   = '0;
    mwdata  = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.m0_req | bus.m1_req) begin
          own_d   = win;
          we_d    = win ? bus.m1_we : bus.m0_we;
          addr_d  = win ? bus.m1_addr : bus.m0_addr;
          wdata_d = win ? bus.m1_wdata
                        : bus.m0_wdata;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        gnt0   = ~own_q;
        gnt1   = own_q;
        mwe    = we_q;
        maddr  = addr_q;
        mwdata = wdata_q;
        last_d = own_q;
        if (we_q) begin
          state_d = IDLE;
        end else if (MEM_LAT == 0) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        maddr = addr_q;
        if (cnt_q == 3'd0) begin
          rdata_d = bus.mem_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        rv0     = ~own_q;
        rv1     = own_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (gnt0 && gnt_cnt0_q != 16'hFFFF)
      gnt_cnt0_d = gnt_cnt0_q + 16'd1;
    if (gnt1 && gnt_cnt1_q != 16'hFFFF)
      gnt_cnt1_d = gnt_cnt1_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      own_q      <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      cnt_q      <= '0;
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      state_q    <= state_d;
      own_q      <= own_d;
      last_q     <= last_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  // reset gates strobes combinationally so an ISSUE write is dropped
  assign bus.m0_gnt    = gnt0 & reset;
  assign bus.m1_gnt    = gnt1 & reset;
  assign bus.m0_rvalid = rv0 & reset;
  assign bus.m1_rvalid = rv1 & reset;
  assign bus.mem_we    = mwe & reset;
  assign bus.mem_addr  = maddr;
  assign bus.mem_wdata = mwdata;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.gnt_cnt0  = gnt_cnt0_q;
  assign bus.gnt_cnt1  = gnt_cnt1_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: three arbiters (MEM_LAT 0/2/3) against
// simple behavioural memories, checked with assertions.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst2, rst3;
  int   checks = 0;
  int   failures = 0;

  dmem_arbiter_if #(.AW(32), .DW(32)) b0 ();
  dmem_arbiter_if #(.AW(32), .DW(32)) b2 ();
  dmem_arbiter_if #(.AW(32), .DW(32)) b3 ();

  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(0))
    u0 (.clk(clk), .reset(rst0), .bus(b0));
  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(2))
    u2 (.clk(clk), .reset(rst2), .bus(b2));
  dmem_arbiter #(.AW(32), .DW(32), .MEM_LAT(3))
    u3 (.clk(clk), .reset(rst3), .bus(b3));

  logic [31:0] mem0 [256];
  logic [31:0] mem2 [256];
  logic [31:0] mem3 [256];
  int wr0 = 0;

  assign b0.mem_rdata = mem0[b0.mem_addr[7:0]];
  assign b2.mem_rdata = mem2[b2.mem_addr[7:0]];
  assign b3.mem_rdata = mem3[b3.mem_addr[7:0]];

  always @(posedge clk) begin
    if (b0.mem_we) begin
      mem0[b0.mem_addr[7:0]] <= b0.mem_wdata;
      wr0 <= wr0 + 1;
    end
    if (b2.mem_we)
      mem2[b2.mem_addr[7:0]] <= b2.mem_wdata;
    if (b3.mem_we)
      mem3[b3.mem_addr[7:0]] <= b3.mem_wdata;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h",
             tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=done");
    $fatal(1, "timeout");
  end

  int order [6];
  int rr_exp [6] = '{0, 1, 0, 1, 0, 1};
  int ng, both, rvc, wsave;

  initial begin
    rst0 = 1'b0; rst2 = 1'b0; rst3 = 1'b0;
    b0.m0_req = 0; b0.m0_we = 0;
    b0.m0_addr = '0; b0.m0_wdata = '0;
    b0.m1_req = 0; b0.m1_we = 0;
    b0.m1_addr = '0; b0.m1_wdata = '0;
    b2.m0_req = 0; b2.m0_we = 0;
    b2.m0_addr = '0; b2.m0_wdata = '0;
    b2.m1_req = 0; b2.m1_we = 0;
    b2.m1_addr = '0; b2.m1_wdata = '0;
    b3.m0_req = 0; b3.m0_we = 0;
    b3.m0_addr = '0; b3.m0_wdata = '0;
    b3.m1_req = 0; b3.m1_we = 0;
    b3.m1_addr = '0; b3.m1_wdata = '0;
    repeat (2) @(negedge clk);

    chk("rst_busy", 32'(b0.busy), 0);
    chk("rst_maddr", b0.mem_addr, 0);
    chk("rst_mwdata", b0.mem_wdata, 0);
    chk("rst_rdata", b0.rdata, 0);
    chk("rst_cnt0", 32'(b0.gnt_cnt0), 0);
    chk("rst_cnt1", 32'(b0.gnt_cnt1), 0);
    chk("rst_mem_we", 32'(b0.mem_we), 0);
    rst0 = 1'b1; rst2 = 1'b1; rst3 = 1'b1;

    // m0 write on u0, preload writes on u2/u3
    b0.m0_req = 1; b0.m0_we = 1;
    b0.m0_addr = 32'h10; b0.m0_wdata = 32'hDEADBEEF;
    b2.m0_req = 1; b2.m0_we = 1;
    b2.m0_addr = 32'h10; b2.m0_wdata = 32'hDEADBEEF;
    b3.m1_req = 1; b3.m1_we = 1;
    b3.m1_addr = 32'h40; b3.m1_wdata = 32'h12345678;
    @(negedge clk);
    chk("wr_gnt0", 32'(b0.m0_gnt), 1);
    chk("wr_gnt1", 32'(b0.m1_gnt), 0);
    chk("wr_mem_we", 32'(b0.mem_we), 1);
    chk("wr_maddr", b0.mem_addr, 32'h10);
    chk("wr_mwdata", b0.mem_wdata, 32'hDEADBEEF);
    chk("wr_busy1", 32'(b0.busy), 1);
    b0.m0_req = 0; b2.m0_req = 0; b3.m1_req = 0;
    @(negedge clk);
    chk("wr_busy2", 32'(b0.busy), 0);
    chk("wr_mem_we2", 32'(b0.mem_we), 0);
    chk("wr_cnt0", 32'(b0.gnt_cnt0), 1);
    chk("wr_mem", mem0[8'h10], 32'hDEADBEEF);

    // m1 read on u2 (MEM_LAT=2)
    b2.m1_req = 1; b2.m1_we = 0; b2.m1_addr = 32'h10;
    @(negedge clk);
    chk("rd2_gnt", 32'(b2.m1_gnt), 1);
    chk("rd2_we", 32'(b2.mem_we), 0);
    chk("rd2_addr1", b2.mem_addr, 32'h10);
    b2.m1_req = 0;
    @(negedge clk);
    chk("rd2_addr2", b2.mem_addr, 32'h10);
    chk("rd2_rv2", 32'(b2.m1_rvalid), 0);
    @(negedge clk);
    chk("rd2_addr3", b2.mem_addr, 32'h10);
    chk("rd2_rv3", 32'(b2.m1_rvalid), 0);
    @(negedge clk);
    chk("rd2_rv4", 32'(b2.m1_rvalid), 1);
    chk("rd2_rv0", 32'(b2.m0_rvalid), 0);
    chk("rd2_gnt4", 32'(b2.m1_gnt), 0);
    chk("rd2_rdata", b2.rdata, 32'hDEADBEEF);
    chk("rd2_resp_addr", b2.mem_addr, 0);
    @(negedge clk);
    chk("rd2_busy5", 32'(b2.busy), 0);
    chk("rd2_hold", b2.rdata, 32'hDEADBEEF);
    chk("rd2_rv5", 32'(b2.m1_rvalid), 0);

    // round-robin on u0 from a fresh reset
    rst0 = 1'b0;
    @(negedge clk);
    rst0 = 1'b1;
    chk("rr_cnt0_rst", 32'(b0.gnt_cnt0), 0);
    b0.m0_req = 1; b0.m0_we = 1;
    b0.m0_addr = 32'h20; b0.m0_wdata = 32'h1;
    b0.m1_req = 1; b0.m1_we = 1;
    b0.m1_addr = 32'h30; b0.m1_wdata = 32'h2;
    ng = 0; both = 0;
    for (int c = 0; c < 40 && ng < 6; c++) begin
      @(negedge clk);
      if (b0.m0_gnt && b0.m1_gnt) both++;
      if (b0.m0_gnt) begin
        order[ng] = 0; ng++;
      end else if (b0.m1_gnt) begin
        order[ng] = 1; ng++;
      end
    end
    b0.m0_req = 0; b0.m1_req = 0;
    chk("rr_grants", 32'(ng), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("rr_order%0d", i),
          32'(order[i]), 32'(rr_exp[i]));
    @(negedge clk);
    chk("rr_both", 32'(both), 0);
    chk("rr_cnt0", 32'(b0.gnt_cnt0), 3);
    chk("rr_cnt1", 32'(b0.gnt_cnt1), 3);
    chk("rr_mem30", mem0[8'h30], 32'h2);

    // reset during ISSUE of a write on u0
    wsave = wr0;
    b0.m0_req = 1; b0.m0_we = 1;
    b0.m0_addr = 32'h50; b0.m0_wdata = 32'hCAFEF00D;
    @(negedge clk);
    chk("rw_pre_we", 32'(b0.mem_we), 1);
    rst0 = 1'b0; b0.m0_req = 0;
    #1;
    chk("rw_we", 32'(b0.mem_we), 0);
    chk("rw_gnt", 32'(b0.m0_gnt), 0);
    @(negedge clk);
    rst0 = 1'b1;
    chk("rw_busy", 32'(b0.busy), 0);
    chk("rw_nowrite", 32'(wr0), 32'(wsave));
    chk("rw_cnt0", 32'(b0.gnt_cnt0), 0);

    // counter saturation on u0
    force u0.gnt_cnt0_q = 16'hFFFE;
    #1;
    release u0.gnt_cnt0_q;
    @(negedge clk);
    chk("sat_pre", 32'(b0.gnt_cnt0), 32'hFFFE);
    b0.m0_req = 1; b0.m0_we = 1;
    b0.m0_addr = 32'h60; b0.m0_wdata = 32'h3;
    ng = 0;
    for (int c = 0; c < 20 && ng < 3; c++) begin
      @(negedge clk);
      if (b0.m0_gnt) ng++;
    end
    b0.m0_req = 0;
    chk("sat_grants", 32'(ng), 3);
    @(negedge clk);
    chk("sat_cnt0", 32'(b0.gnt_cnt0), 32'hFFFF);
    @(negedge clk);
    chk("sat_hold", 32'(b0.gnt_cnt0), 32'hFFFF);

    // u3 (MEM_LAT=3): full read, then an aborted read
    b3.m0_req = 1; b3.m0_we = 0; b3.m0_addr = 32'h40;
    @(negedge clk);
    chk("rd3_gnt", 32'(b3.m0_gnt), 1);
    b3.m0_req = 0;
    repeat (3) @(negedge clk);
    chk("rd3_addr", b3.mem_addr, 32'h40);
    chk("rd3_rv_early", 32'(b3.m0_rvalid), 0);
    @(negedge clk);
    chk("rd3_rv", 32'(b3.m0_rvalid), 1);
    chk("rd3_rdata", b3.rdata, 32'h12345678);
    @(negedge clk);
    b3.m0_req = 1;
    @(negedge clk);
    chk("ab_gnt", 32'(b3.m0_gnt), 1);
    b3.m0_req = 0;
    @(negedge clk);
    chk("ab_busy", 32'(b3.busy), 1);
    rst3 = 1'b0;
    #1;
    chk("ab_rv_rst", 32'(b3.m0_rvalid), 0);
    @(negedge clk);
    rst3 = 1'b1;
    chk("ab_busy_after", 32'(b3.busy), 0);
    chk("ab_rdata", b3.rdata, 0);
    rvc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (b3.m0_rvalid) rvc++;
    end
    chk("ab_no_rv", 32'(rvc), 0);
    b3.m1_req = 1; b3.m1_we = 0; b3.m1_addr = 32'h40;
    @(negedge clk);
    chk("ab_m1_gnt", 32'(b3.m1_gnt), 1);
    b3.m1_req = 0;
    repeat (4) @(negedge clk);
    chk("ab_m1_rv", 32'(b3.m1_rvalid), 1);
    chk("ab_m1_rdata", b3.rdata, 32'h12345678);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, request/memory address width.
REQ-002 SHALL have parameter DW, default 32, data width.
REQ-003 SHALL have parameter MEM_LAT, default 0, memory read latency in cycles (0..7); 0 = combinational read.
REQ-004 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- m0_req  in  1  core request, held until m0_gnt
- m0_we  in  1  core write enable (1 = write, 0 = read)
- m0_addr  in  AW  core address
- m0_wdata  in  DW  core write data
- m0_gnt  out  1  one-cycle grant pulse to core
- m0_rvalid  out  1  one-cycle read-data-valid pulse to core
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid: same as m0_*, for the debug/loader port
- rdata  out  DW  captured read data, shared by both ports
- mem_we  out  1  data-memory write strobe
- mem_addr  out  AW  data-memory address
- mem_wdata  out  DW  data-memory write data
- mem_rdata  in  DW  data-memory read data
- busy  out  1  high whenever state is not IDLE
- gnt_cnt0, gnt_cnt1  out  16  saturating grant counters, one per port

Function
REQ-005 SHALL implement the FSM states IDLE, ISSUE, WAIT and RESP.
REQ-006 IDLE: if any req is high, SHALL select a winner, latch the winner's we/addr/wdata and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-007 SHALL arbitrate round-robin: if both reqs are high, the port not granted last wins; after reset port 0 is preferred.
REQ-008 SHALL sample req only in IDLE; a requester SHALL hold req/we/addr/wdata stable until its gnt; a req dropped before selection is ignored.
REQ-009 ISSUE (exactly 1 cycle): SHALL pulse the winner's gnt, drive mem_addr/mem_wdata from the latched values and assert mem_we only for a write.
REQ-010 Write: SHALL go ISSUE -> IDLE; the earliest next grant is 2 cycles after the previous gnt.
REQ-011 Read with MEM_LAT=0: SHALL capture mem_rdata into rdata at the end of ISSUE and go to RESP.
REQ-012 Read with MEM_LAT>0: SHALL go to WAIT for MEM_LAT cycles with mem_addr held and mem_we low, capture mem_rdata at the end of the last WAIT cycle, then go to RESP.
REQ-013 RESP (1 cycle): SHALL pulse the owner's rvalid, hold rdata and return to IDLE; rdata SHALL stay unchanged until the next read capture.
REQ-014 Read latency SHALL be: req in cycle 0 -> gnt in cycle 1 -> rvalid in cycle 2+MEM_LAT.
REQ-015 In IDLE and RESP, SHALL drive mem_addr, mem_wdata and mem_we to 0.
REQ-016 SHALL never assert both gnts, both rvalids, or gnt together with rvalid on the same port in one cycle.
REQ-017 gnt_cntN SHALL increment on each mN_gnt pulse and saturate at 0xFFFF.
REQ-018 The last-granted pointer SHALL update in ISSUE only.

Reset
REQ-019 While reset=0 at a rising edge: state SHALL become IDLE; pointer SHALL prefer port 0; rdata, counters and latched request SHALL become 0.
REQ-020 While reset=0: mem_we, both gnts and both rvalids SHALL be 0 combinationally, so reset during ISSUE suppresses the write.
REQ-021 Reset mid-read SHALL abort the transaction with no rvalid issued afterwards.
REQ-022 Outputs after reset: busy=0, mem_addr=0, mem_wdata=0, rdata=0, gnt_cnt0=gnt_cnt1=0.

Verification
REQ-023 m0 write addr=0x10, wdata=0xDEADBEEF, MEM_LAT=0 -> m0_gnt and mem_we=1 in cycle 1 with mem_addr=0x10; busy=0 in cycle 2.
REQ-024 m1 read addr=0x10, MEM_LAT=2, mem model returns 0xDEADBEEF -> m1_gnt in cycle 1, mem_addr=0x10 held in cycles 1-3, m1_rvalid in cycle 4 with rdata=0xDEADBEEF.
REQ-025 Both reqs held continuously with writes, 6 grants -> grant order m0, m1, m0, m1, m0, m1; gnt_cnt0=gnt_cnt1=3; no cycle has both gnts high.
REQ-026 m0 read with MEM_LAT=3, reset=0 driven in the first WAIT cycle -> no m0_rvalid; busy=0 and rdata=0 in the next cycle; a following m1 request is granted normally.
REQ-027 Reset=0 in the ISSUE cycle of a write -> mem_we=0 that cycle; a memory scoreboard shows no write.
REQ-028 Force gnt_cnt0 to 0xFFFE, then 3 m0 grants -> gnt_cnt0 reads 0xFFFF and stays there.
